// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// PC/memory-request sequencer for the single-cycle MIPS core. Each cycle it
// decides whether the PC may advance. It issues instruction-fetch and
// data-memory requests, and it holds the PC until the outstanding fetch or
// load/store gets its hit. It also latches HALT and keeps the retired-
// instruction and cycle counters.
//
// Ports:
//   CLK, nRST          clock (rising edge), async active-low reset
//   ihit, dhit         instruction / data memory hit
//   memread, memwrite  load / store decode of the current instruction
//   halt_in            HALT decode of the current instruction
//   imemREN            instruction read request
//   dmemREN, dmemWEN   data read / write request
//   pcen               PC advance enable
//   halt               sticky halt flag
//   icount, ccount     retired-instruction and cycle counters (CNT_W bits)
//
// state   | meaning
// IFETCH  | fetching; advance PC on ihit unless mem op or HALT
// DACCESS | load/store outstanding; PC held until dhit
// HALTED  | terminal until reset; counters frozen
module fetch_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memread,
    input  logic             memwrite,
    input  logic             halt_in,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pcen,
    output logic             halt,
    output logic [CNT_W-1:0] icount,
    output logic [CNT_W-1:0] ccount
);

    typedef enum logic [1:0] {
        IFETCH  = 2'd0,
        DACCESS = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    logic [CNT_W-1:0] ccount_q, ccount_d;
    logic             enter_halt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IFETCH;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            halt_q   <= 1'b0;
            icount_q <= '0;
            ccount_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            halt_q   <= halt_d;
            icount_q <= icount_d;
            ccount_q <= ccount_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        imemREN    = 1'b0;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        pcen       = 1'b0;
        enter_halt = 1'b0;

        case (state_q)
            IFETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    if (halt_in) begin
                        state_d    = HALTED;
                        enter_halt = 1'b1;
                    end else if (memread || memwrite) begin
                        // Write wins when both decode bits are set.
                        rd_d    = memread & ~memwrite;
                        wr_d    = memwrite;
                        state_d = DACCESS;
                    end else begin
                        pcen = 1'b1;
                    end
                end
            end
            DACCESS: begin
                // Only the latched op is used; live decode may have moved on.
                dmemREN = rd_q;
                dmemWEN = wr_q;
                if (dhit) begin
                    pcen    = 1'b1;
                    state_d = IFETCH;
                end
            end
            HALTED: begin
            end
            default: state_d = IFETCH;
        endcase

        halt_d   = halt_q | enter_halt;
        // HALT itself counts as a retired instruction.
        icount_d = (pcen || enter_halt) ? icount_q + CNT_W'(1) : icount_q;
        ccount_d = (state_q != HALTED)  ? ccount_q + CNT_W'(1) : ccount_q;
    end

    assign halt   = halt_q;
    assign icount = icount_q;
    assign ccount = ccount_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, memread, memwrite, halt_in;
    logic        imemREN, dmemREN, dmemWEN, pcen, halt;
    logic [31:0] icount, ccount;
    logic        imemREN4, dmemREN4, dmemWEN4, pcen4, halt4;
    logic [3:0]  icount4, ccount4;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fetch_sequencer u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .memread(memread), .memwrite(memwrite), .halt_in(halt_in),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pcen(pcen), .halt(halt), .icount(icount), .ccount(ccount)
    );

    fetch_sequencer #(.CNT_W(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .memread(memread), .memwrite(memwrite), .halt_in(halt_in),
        .imemREN(imemREN4), .dmemREN(dmemREN4), .dmemWEN(dmemWEN4),
        .pcen(pcen4), .halt(halt4), .icount(icount4), .ccount(ccount4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0;
        memread = 1'b0; memwrite = 1'b0; halt_in = 1'b0;
        #3;
        chk("rst_imemREN", imemREN, 1);
        chk("rst_pcen", pcen, 0);
        chk("rst_dmemREN", dmemREN, 0);
        chk("rst_dmemWEN", dmemWEN, 0);
        chk("rst_halt", halt, 0);
        chk("rst_icount", icount, 0);
        chk("rst_ccount", ccount, 0);

        // three single-cycle instructions
        step();
        nRST = 1'b1; ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("alu_pcen", pcen, 1);
            chk("alu_dmemREN", dmemREN, 0);
            step();
        end
        chk("alu_icount", icount, 3);
        chk("alu_ccount", ccount, 3);

        // load with two wait cycles
        memread = 1'b1;
        #1;
        chk("ld_issue_pcen", pcen, 0);
        chk("ld_issue_imemREN", imemREN, 1);
        step();
        ihit = 1'b0; memread = 1'b0; dhit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ld_wait_dmemREN", dmemREN, 1);
            chk("ld_wait_imemREN", imemREN, 0);
            chk("ld_wait_pcen", pcen, 0);
            step();
        end
        dhit = 1'b1;
        #1;
        chk("ld_hit_dmemREN", dmemREN, 1);
        chk("ld_hit_pcen", pcen, 1);
        step();
        dhit = 1'b0;
        chk("ld_icount", icount, 4);
        chk("ld_ccount", ccount, 7);
        chk("ld_back_imemREN", imemREN, 1);

        // store with both decode bits set; memwrite dropped mid-access
        ihit = 1'b1; memread = 1'b1; memwrite = 1'b1;
        #1;
        chk("st_issue_pcen", pcen, 0);
        step();
        memread = 1'b0; memwrite = 1'b0;
        #1;
        chk("st_dmemWEN", dmemWEN, 1);
        chk("st_dmemREN", dmemREN, 0);
        chk("st_pcen_ihit_ignored", pcen, 0);
        step();
        chk("st_dmemWEN_held", dmemWEN, 1);
        dhit = 1'b1;
        #1;
        chk("st_hit_pcen", pcen, 1);
        step();
        dhit = 1'b0; ihit = 1'b0;
        chk("st_icount", icount, 5);
        chk("st_ccount", ccount, 10);

        // ihit with spurious dhit in IFETCH
        ihit = 1'b1; dhit = 1'b1;
        #1;
        chk("sp_pcen", pcen, 1);
        chk("sp_dmemREN", dmemREN, 0);
        step();
        chk("sp_imemREN", imemREN, 1);
        ihit = 1'b0; dhit = 1'b0;

        // halt_in without ihit does nothing
        halt_in = 1'b1;
        #1;
        chk("hnoi_pcen", pcen, 0);
        step();
        chk("hnoi_halt", halt, 0);
        chk("hnoi_icount", icount, 6);
        chk("hnoi_ccount", ccount, 12);

        // HALT wins over memwrite
        ihit = 1'b1; memwrite = 1'b1;
        #1;
        chk("h_dmemWEN", dmemWEN, 0);
        chk("h_pcen", pcen, 0);
        step();
        chk("h_halt", halt, 1);
        chk("h_icount", icount, 7);
        chk("h_ccount", ccount, 13);
        memwrite = 1'b0; halt_in = 1'b0; dhit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("hd_pcen", pcen, 0);
            chk("hd_imemREN", imemREN, 0);
            step();
        end
        chk("hd_icount", icount, 7);
        chk("hd_ccount", ccount, 13);
        chk("hd_halt", halt, 1);

        // reset in the middle of a load
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0;
        #1;
        nRST = 1'b1; ihit = 1'b1; memread = 1'b1;
        step();
        chk("ra_dmemREN", dmemREN, 1);
        chk("ra_dmemWEN", dmemWEN, 0);
        ihit = 1'b0; memread = 1'b0;
        nRST = 1'b0;
        #1;
        chk("ra_dmemREN_drop", dmemREN, 0);
        chk("ra_dmemWEN_drop", dmemWEN, 0);
        chk("ra_imemREN", imemREN, 1);
        chk("ra_halt", halt, 0);
        chk("ra_icount", icount, 0);
        chk("ra_ccount", ccount, 0);
        step();

        // 16 single-cycle instructions: 4-bit counters wrap
        nRST = 1'b1; ihit = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("wr_pcen", pcen, 1);
            chk("wr_pcen4", pcen4, 1);
            step();
        end
        chk("wr_icount4", icount4, 0);
        chk("wr_ccount4", ccount4, 0);
        chk("wr_icount", icount, 16);
        chk("wr_imemREN4", imemREN4, 1);
        chk("wr_halt4", halt4, 0);
        #1;
        chk("wr_after_pcen4", pcen4, 1);
        step();
        chk("wr_after_icount4", icount4, 1);
        ihit = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
